// File: rtl/waveform_pkg.sv
// Shared constants, colour codes and helpers for the scope-style waveform renderer.
package waveform_pkg;

  typedef enum logic [3:0] {
    CC_BG    = 4'h0,
    CC_CLIP  = 4'h1,
    CC_TRACE = 4'h2,
    CC_GRID  = 4'h5,
    CC_AXIS  = 4'h6,
    CC_BLACK = 4'h7
  } colour_code_e;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int AXIS_ROW = 240;

  // Pixel attributes carried alongside the RAM read.
  typedef struct packed {
    logic       active;
    logic       col_valid;
    logic       x_grid;
    logic [9:0] y;
  } pix_stage_t;

  // 17-bit magnitude so that -32768 maps to 32768 without overflow.
  function automatic logic [16:0] mag17(input logic [15:0] s);
    mag17 = s[15] ? ({1'b0, ~s} + 17'd1) : {1'b0, s};
  endfunction

endpackage

// File: rtl/waveform_pixel_gen_if.sv
// Audio sample stream from the effect chain into the waveform renderer.
interface waveform_pixel_gen_if;
  logic        sample_valid;
  logic [15:0] sample;

  modport master (output sample_valid, output sample);
  modport slave  (input  sample_valid, input  sample);
endinterface

// File: rtl/wave_sample_ram.sv
// 640x8 simple dual-port column buffer: synchronous write, registered read (read-before-write).
module wave_sample_ram
  import waveform_pkg::*;
(
  input  logic       Clk,
  input  logic       we,
  input  logic [9:0] waddr,
  input  logic [7:0] wdata,
  input  logic [9:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem_q [H_ACTIVE];
  logic [7:0] rdata_q;

  always_ff @(posedge Clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/waveform_pixel_gen.sv
// Waveform renderer: decimated capture into a circular column buffer, 2-cycle pixel colour pipeline.
// Optional WAVE_PEAK_EN: store the largest-magnitude sample of each decimation window.
module waveform_pixel_gen
  import waveform_pkg::*;
#(
  parameter int          DECIM      = 16,
  parameter int          TRACE_HALF = 1,
  parameter logic [15:0] CLIP_THR   = 16'd32000,
  parameter int          CLIP_HOLD  = 30
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  waveform_pixel_gen_if.slave  smp,
  input  logic                 freeze,
  input  logic                 blank,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  output logic [3:0]           Colorcode
);

  localparam int               CLIP_W     = $clog2(CLIP_HOLD + 1);
  localparam logic [7:0]       DECIM_LAST = 8'(DECIM - 1);
  localparam logic signed [11:0] TH       = 12'(TRACE_HALF);

  logic [9:0]        wr_ptr_q, wr_ptr_d;
  logic [9:0]        start_ptr_q, start_ptr_d;
  logic [7:0]        decim_cnt_q, decim_cnt_d;
  logic [9:0]        fill_cnt_q, fill_cnt_d;
  logic [9:0]        fill_snap_q, fill_snap_d;
  logic [CLIP_W-1:0] clip_cnt_q, clip_cnt_d;
  logic              frozen_q, frozen_d;
  logic              origin_q, origin_d;
  pix_stage_t        st1_q, st1_d;
  colour_code_e      color_q, color_d;

  logic        origin, frame_start, accept, store, clip_hit, trace_hit;
  logic [7:0]  store_s8, rd_data;
  logic [10:0] addr_sum;
  logic [9:0]  rd_addr;
  logic signed [11:0] y_col, dy;

  assign origin      = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign frame_start = origin && !origin_q;
  assign origin_d    = origin;
  assign accept      = smp.sample_valid && !frozen_q;
  assign store       = accept && (decim_cnt_q == DECIM_LAST);
  assign clip_hit    = accept && (mag17(smp.sample) >= {1'b0, CLIP_THR});

`ifdef WAVE_PEAK_EN
  logic [15:0] peak_q, peak_d, pick;

  // The first sample of a window always replaces whatever the register holds.
  always_comb begin
    pick = smp.sample;
    if (decim_cnt_q != 8'd0 && mag17(peak_q) >= mag17(smp.sample)) begin
      pick = peak_q;
    end
    peak_d = peak_q;
    if (accept) begin
      peak_d = store ? 16'd0 : pick;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) peak_q <= '0;
    else          peak_q <= peak_d;
  end

  assign store_s8 = pick[15:8];
`else
  assign store_s8 = smp.sample[15:8];
`endif

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    decim_cnt_d = decim_cnt_q;
    fill_cnt_d  = fill_cnt_q;
    if (accept) begin
      if (store) begin
        decim_cnt_d = 8'd0;
        wr_ptr_d    = (wr_ptr_q == 10'(H_ACTIVE - 1)) ? 10'd0 : wr_ptr_q + 10'd1;
        if (fill_cnt_q != 10'(H_ACTIVE)) fill_cnt_d = fill_cnt_q + 10'd1;
      end else begin
        decim_cnt_d = decim_cnt_q + 8'd1;
      end
    end
  end

  // Picture geometry is only re-latched at frame start; a clip load overrides the decay.
  always_comb begin
    frozen_d    = frozen_q;
    start_ptr_d = start_ptr_q;
    fill_snap_d = fill_snap_q;
    clip_cnt_d  = clip_cnt_q;
    if (frame_start) begin
      frozen_d = freeze;
      if (!freeze) begin
        start_ptr_d = wr_ptr_q;
        fill_snap_d = fill_cnt_q;
      end
      if (clip_cnt_q != '0) clip_cnt_d = clip_cnt_q - 1'b1;
    end
    if (clip_hit) clip_cnt_d = CLIP_W'(CLIP_HOLD);
  end

  always_comb begin
    addr_sum = {1'b0, start_ptr_q} + {1'b0, DrawX};
    if (addr_sum >= 11'd1280)     rd_addr = 10'(addr_sum - 11'd1280);
    else if (addr_sum >= 11'd640) rd_addr = 10'(addr_sum - 11'd640);
    else                          rd_addr = addr_sum[9:0];

    st1_d.active    = (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE)) && blank;
    st1_d.col_valid = DrawX >= (10'(H_ACTIVE) - fill_snap_q);
    st1_d.x_grid    = (DrawX[5:0] == 6'd0);
    st1_d.y         = DrawY;
  end

  wave_sample_ram u_ram (
    .Clk   (Clk),
    .we    (store),
    .waddr (wr_ptr_q),
    .wdata (store_s8),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    y_col     = 12'sd240 - $signed({{4{rd_data[7]}}, rd_data});
    dy        = $signed({2'b00, st1_q.y}) - y_col;
    trace_hit = st1_q.col_valid && (dy <= TH) && (dy >= -TH);

    color_d = CC_BLACK;
    if (st1_q.active) begin
      if (clip_cnt_q != '0 && st1_q.y < 10'd8)          color_d = CC_CLIP;
      else if (trace_hit)                               color_d = CC_TRACE;
      else if (st1_q.y == 10'(AXIS_ROW))                color_d = CC_AXIS;
      else if (st1_q.x_grid || st1_q.y[5:0] == 6'd0)    color_d = CC_GRID;
      else                                              color_d = CC_BG;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q    <= '0;
      start_ptr_q <= '0;
      decim_cnt_q <= '0;
      fill_cnt_q  <= '0;
      fill_snap_q <= '0;
      clip_cnt_q  <= '0;
      frozen_q    <= 1'b0;
      origin_q    <= 1'b0;
      st1_q       <= '0;
      color_q     <= CC_BLACK;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      start_ptr_q <= start_ptr_d;
      decim_cnt_q <= decim_cnt_d;
      fill_cnt_q  <= fill_cnt_d;
      fill_snap_q <= fill_snap_d;
      clip_cnt_q  <= clip_cnt_d;
      frozen_q    <= frozen_d;
      origin_q    <= origin_d;
      st1_q       <= st1_d;
      color_q     <= color_d;
    end
  end

  assign Colorcode = color_q;

endmodule

// File: tb/tb_waveform_pixel_gen.sv
// Scoreboard bench for waveform_pixel_gen: a DECIM=1 instance for most checks, a DECIM=4 one for windowing.
module tb_waveform_pixel_gen;

  logic       clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       freeze, blank;
  logic [9:0] DrawX, DrawY;
  logic [3:0] cc1, cc4;

  waveform_pixel_gen_if s1 ();
  waveform_pixel_gen_if s4 ();

  waveform_pixel_gen #(.DECIM(1)) dut (
    .Clk(clk), .Reset_n(Reset_n), .smp(s1), .freeze(freeze), .blank(blank),
    .DrawX(DrawX), .DrawY(DrawY), .Colorcode(cc1)
  );

  waveform_pixel_gen #(.DECIM(4)) dut4 (
    .Clk(clk), .Reset_n(Reset_n), .smp(s4), .freeze(freeze), .blank(blank),
    .DrawX(DrawX), .DrawY(DrawY), .Colorcode(cc4)
  );

  always #5 clk = ~clk;

`ifdef WAVE_PEAK_EN
  localparam int T6 = 330;
`else
  localparam int T6 = 235;
`endif

  typedef struct {
    int         due;
    logic [3:0] exp;
    bit         sel;
    int         x;
    int         y;
    int         tag;
  } sb_ent_t;

  sb_ent_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  sb_ent_t    mon_e;
  logic [3:0] mon_got;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e   = sb.pop_front();
      mon_got = mon_e.sel ? cc4 : cc1;
      total++;
      if (mon_got !== mon_e.exp || mon_e.due != cyc) begin
        bad++;
        $display("FAIL t%0d dut%0d px(%0d,%0d) got=%h want=%h", mon_e.tag,
                 mon_e.sel ? 4 : 1, mon_e.x, mon_e.y, mon_got, mon_e.exp);
      end else begin
        $display("ok   t%0d dut%0d px(%0d,%0d) cc=%h", mon_e.tag, mon_e.sel ? 4 : 1,
                 mon_e.x, mon_e.y, mon_got);
      end
    end
  end

  task automatic park();
    DrawX = 10'd799;
    DrawY = 10'd524;
  endtask

  task automatic probe(input int x, input int y, input logic b, input logic [3:0] exp,
                       input bit sel, input int tag);
    sb_ent_t e;
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    e.due = cyc + 2;
    e.exp = exp;
    e.sel = sel;
    e.x   = x;
    e.y   = y;
    e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    blank = 1'b1;
  endtask

  task automatic send(input logic [15:0] v, input bit sel);
    if (sel) begin
      s4.sample_valid = 1'b1; s4.sample = v;
    end else begin
      s1.sample_valid = 1'b1; s1.sample = v;
    end
    @(negedge clk);
    s1.sample_valid = 1'b0;
    s4.sample_valid = 1'b0;
  endtask

  task automatic frame_start();
    DrawX = 10'd0;
    DrawY = 10'd0;
    @(negedge clk);
    park();
    @(negedge clk);
  endtask

  task automatic check(input int tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL t%0d direct got=%h want=%h", tag, got, exp);
    end else begin
      $display("ok   t%0d direct cc=%h", tag, got);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    freeze = 1'b0;
    blank  = 1'b1;
    park();
    s1.sample_valid = 1'b0; s1.sample = 16'h0;
    s4.sample_valid = 1'b0; s4.sample = 16'h0;
    repeat (3) @(negedge clk);
    check(0, cc1, 4'h7);
    check(0, cc4, 4'h7);
    Reset_n = 1'b1;
    @(negedge clk);
    check(0, cc1, 4'h7);

    // 1: empty buffer, static layers only
    frame_start();
    probe(100, 240, 1'b1, 4'h6, 0, 1);
    probe(64, 100, 1'b1, 4'h5, 0, 1);
    probe(10, 10, 1'b1, 4'h0, 0, 1);
    probe(10, 10, 1'b0, 4'h7, 0, 1);
    probe(700, 10, 1'b1, 4'h7, 0, 1);
    probe(10, 500, 1'b1, 4'h7, 0, 1);
    probe(300, 239, 1'b1, 4'h0, 0, 1);
    probe(300, 241, 1'b1, 4'h0, 0, 1);
    probe(10, 3, 1'b1, 4'h0, 0, 1);

    // 6: DECIM=4 window {10,-90,40,5}<<8 lands in the newest column
    send(16'h0A00, 1); send(16'hA600, 1); send(16'h2800, 1); send(16'h0500, 1);
    frame_start();
    probe(639, T6, 1'b1, 4'h2, 1, 6);
    probe(639, T6 + 1, 1'b1, 4'h2, 1, 6);
    probe(639, T6 + 2, 1'b1, 4'h0, 1, 6);
    probe(638, T6, 1'b1, 4'h0, 1, 6);
    drain();

    // 2: full buffer of 0x1000 -> trace rows 223..225
    park();
    for (int i = 0; i < 640; i++) send(16'h1000, 0);
    frame_start();
    probe(0, 223, 1'b1, 4'h2, 0, 2);
    probe(0, 224, 1'b1, 4'h2, 0, 2);
    probe(0, 225, 1'b1, 4'h2, 0, 2);
    probe(639, 225, 1'b1, 4'h2, 0, 2);
    probe(320, 224, 1'b1, 4'h2, 0, 2);
    probe(100, 222, 1'b1, 4'h0, 0, 2);
    probe(100, 226, 1'b1, 4'h0, 0, 2);
    drain();

    // 3: 641-sample ramp; sample k has s8 = (k%200)-100
    park();
    for (int k = 0; k <= 640; k++) send(16'(((k % 200) - 100) * 256), 0);
    frame_start();
    probe(0, 339, 1'b1, 4'h2, 0, 3);
    probe(0, 338, 1'b1, 4'h2, 0, 3);
    probe(0, 340, 1'b1, 4'h2, 0, 3);
    probe(0, 341, 1'b1, 4'h5, 0, 3);
    probe(1, 338, 1'b1, 4'h2, 0, 3);
    probe(639, 300, 1'b1, 4'h2, 0, 3);
    probe(639, 302, 1'b1, 4'h0, 0, 3);
    probe(639, 340, 1'b1, 4'h0, 0, 3);
    drain();

    // 4: full-scale negative sample lights the clip bar for 30 frames
    park();
    send(16'h8000, 0);
    probe(100, 3, 1'b1, 4'h1, 0, 4);
    probe(100, 7, 1'b1, 4'h1, 0, 4);
    probe(100, 0, 1'b1, 4'h1, 0, 4);
    probe(100, 8, 1'b1, 4'h0, 0, 4);
    for (int f = 1; f <= 29; f++) begin
      frame_start();
      probe(100, 3, 1'b1, 4'h1, 0, 4);
    end
    frame_start();
    probe(100, 3, 1'b1, 4'h0, 0, 4);
    drain();

    // 4b: frozen picture ignores samples (and their clip) for 3 frames
    freeze = 1'b1;
    frame_start();
    for (int i = 0; i < 20; i++) send(16'h7F00, 0);
    for (int f = 0; f < 3; f++) begin
      frame_start();
      probe(639, 368, 1'b1, 4'h2, 0, 7);
      probe(0, 338, 1'b1, 4'h2, 0, 7);
      probe(638, 300, 1'b1, 4'h2, 0, 7);
      probe(0, 113, 1'b1, 4'h5, 0, 7);
      probe(100, 3, 1'b1, 4'h0, 0, 7);
    end
    freeze = 1'b0;
    frame_start();
    drain();

    // 5: write and read of column 0's address in the same cycle -> old data
    s1.sample_valid = 1'b1;
    s1.sample = 16'h2000;
    probe(0, 338, 1'b1, 4'h2, 0, 5);
    s1.sample_valid = 1'b0;
    probe(0, 338, 1'b1, 4'h5, 0, 5);
    probe(0, 208, 1'b1, 4'h2, 0, 5);

    // 5b: reset mid-line forces black and hides the buffer
    probe(64, 100, 1'b1, 4'h5, 0, 5);
    drain();
    check(5, cc1, 4'h5);
    Reset_n = 1'b0;
    #1;
    check(5, cc1, 4'h7);
    @(negedge clk);
    check(5, cc1, 4'h7);
    Reset_n = 1'b1;
    @(negedge clk);
    frame_start();
    probe(0, 208, 1'b1, 4'h5, 0, 8);
    probe(100, 240, 1'b1, 4'h6, 0, 8);
    probe(639, 368, 1'b1, 4'h0, 0, 8);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
